// File: rtl/audio_pkg.sv
// audio_pkg: constants and state encoding shared by the gain stage and its
// helpers.
//   SAMPLE_W  : default audio sample width (signed two's complement)
//   GAIN_FRAC : fractional bits of the unsigned gain word (Q8.8)
//   GAIN_W    : gain word width
//   SAT_MAX / SAT_MIN : clip limits for a 16-bit sample
//   state_e   : sequencer states of gain_stage
package audio_pkg;

   localparam int unsigned SAMPLE_W  = 16;
   localparam int unsigned GAIN_FRAC = 8;
   localparam int unsigned GAIN_W    = 16;

   localparam logic [15:0] SAT_MAX = 16'h7FFF;
   localparam logic [15:0] SAT_MIN = 16'h8000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage : audio_pkg

// File: rtl/gain_stage_edge_sync.sv
// edge_sync: brings an asynchronous level into the clk domain through a
// 2-flop synchronizer and emits a one-cycle pulse for every rising edge.
//   clk      : system clock
//   rst_n    : synchronous active-low reset
//   async_in : asynchronous level input
//   rise     : one-cycle pulse per rising edge of async_in (after sync)
module edge_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic async_in,
   output logic rise
);

   logic sync1_q, sync1_d;
   logic sync2_q, sync2_d;
   logic sync3_q, sync3_d;

   always_comb begin
      sync1_d = async_in;
      sync2_d = sync1_q;
      sync3_d = sync2_q;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         sync3_q <= 1'b0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         sync3_q <= sync3_d;
      end
   end

   // sync3 only delays sync2 for edge detection; it is not a metastability stage
   assign rise = sync2_q & ~sync3_q;

endmodule : edge_sync

// File: rtl/gain_stage.sv
// gain_stage: applies an unsigned Q8.8 gain to a signed ADC sample using a
// bit-serial shift-and-add multiplier (one gain bit per clk, LSB first).
//   clk          : system clock
//   rst_n        : synchronous active-low reset
//   adc_clock    : asynchronous sample strobe, one sample per rising edge
//   data_in      : signed ADC sample
//   gain         : unsigned Q8.8 gain, 0x0100 = unity
//   sample_out   : signed gained sample, held until the next result
//   sample_valid : one-cycle pulse when sample_out updates
//   busy         : high while a sample is being processed (MUL, DONE)
//   sat          : result was clipped; updates together with sample_out
//   overrun      : sticky; a strobe arrived while busy and was dropped
module gain_stage #(
   parameter int unsigned SAMPLE_W  = audio_pkg::SAMPLE_W,
   parameter int unsigned GAIN_FRAC = audio_pkg::GAIN_FRAC
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                adc_clock,
   input  logic [SAMPLE_W-1:0] data_in,
   input  logic [15:0]         gain,
   output logic [SAMPLE_W-1:0] sample_out,
   output logic                sample_valid,
   output logic                busy,
   output logic                sat,
   output logic                overrun
);

   import audio_pkg::*;

   localparam int unsigned ACC_W = SAMPLE_W + GAIN_W;

   localparam logic [SAMPLE_W-1:0] CLIP_MAX = {1'b0, {(SAMPLE_W-1){1'b1}}};
   localparam logic [SAMPLE_W-1:0] CLIP_MIN = {1'b1, {(SAMPLE_W-1){1'b0}}};

   state_e                     state_q, state_d;
   logic [SAMPLE_W-1:0]        data_q, data_d;
   logic [GAIN_W-1:0]          gain_q, gain_d;
   logic signed [ACC_W-1:0]    acc_q, acc_d;
   logic [3:0]                 bit_q, bit_d;
   logic [SAMPLE_W-1:0]        sample_q, sample_d;
   logic                       valid_q, valid_d;
   logic                       sat_q, sat_d;
   logic                       overrun_q, overrun_d;

   logic                       rise;
   logic signed [ACC_W-1:0]    partial;
   logic signed [ACC_W-1:0]    shifted;
   logic [ACC_W-SAMPLE_W:0]    hi_bits;
   logic                       clip;

   edge_sync u_edge_sync (
      .clk      (clk),
      .rst_n    (rst_n),
      .async_in (adc_clock),
      .rise     (rise)
   );

   // Sign-extended sample moved to the weight of the current gain bit.
   assign partial = $signed({{GAIN_W{data_q[SAMPLE_W-1]}}, data_q}) <<< bit_q;

   // Arithmetic shift truncates toward negative infinity. The result fits in
   // SAMPLE_W bits only when every bit from the sample MSB upward agrees.
   assign shifted = acc_q >>> GAIN_FRAC;
   assign hi_bits = shifted[ACC_W-1:SAMPLE_W-1];
   assign clip    = !((&hi_bits) || (~|hi_bits));

   always_comb begin
      state_d   = state_q;
      data_d    = data_q;
      gain_d    = gain_q;
      acc_d     = acc_q;
      bit_d     = bit_q;
      sample_d  = sample_q;
      valid_d   = 1'b0;
      sat_d     = sat_q;
      overrun_d = overrun_q;

      // DONE also counts as busy, so a strobe on the return-to-IDLE cycle is dropped.
      if (rise && (state_q != IDLE)) begin
         overrun_d = 1'b1;
      end

      unique case (state_q)
         IDLE: begin
            if (rise) begin
               data_d  = data_in;
               gain_d  = gain;
               acc_d   = '0;
               bit_d   = '0;
               state_d = MUL;
            end
         end
         MUL: begin
            if (gain_q[bit_q]) begin
               acc_d = acc_q + partial;
            end
            if (bit_q == 4'd15) begin
               state_d = DONE;
            end else begin
               bit_d = bit_q + 4'd1;
            end
         end
         DONE: begin
            if (clip) begin
               sample_d = shifted[ACC_W-1] ? CLIP_MIN : CLIP_MAX;
            end else begin
               sample_d = shifted[SAMPLE_W-1:0];
            end
            sat_d   = clip;
            valid_d = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         data_q    <= '0;
         gain_q    <= '0;
         acc_q     <= '0;
         bit_q     <= '0;
         sample_q  <= '0;
         valid_q   <= 1'b0;
         sat_q     <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         data_q    <= data_d;
         gain_q    <= gain_d;
         acc_q     <= acc_d;
         bit_q     <= bit_d;
         sample_q  <= sample_d;
         valid_q   <= valid_d;
         sat_q     <= sat_d;
         overrun_q <= overrun_d;
      end
   end

   assign sample_out   = sample_q;
   assign sample_valid = valid_q;
   assign busy         = (state_q != IDLE);
   assign sat          = sat_q;
   assign overrun      = overrun_q;

endmodule : gain_stage

// File: tb/tb_gain_stage.sv
// Directed bench for gain_stage: reset state, unity/saturating/truncating
// products, zero gain, overrun, and reset in the middle of a multiply.
module tb_gain_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        adc_clock;
   logic [15:0] data_in;
   logic [15:0] gain;
   logic [15:0] sample_out;
   logic        sample_valid;
   logic        busy;
   logic        sat;
   logic        overrun;

   int unsigned n_pass  = 0;
   int unsigned n_total = 0;

   always #5 clk = ~clk;

   gain_stage #(.SAMPLE_W(16), .GAIN_FRAC(8)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .adc_clock    (adc_clock),
      .data_in      (data_in),
      .gain         (gain),
      .sample_out   (sample_out),
      .sample_valid (sample_valid),
      .busy         (busy),
      .sat          (sat),
      .overrun      (overrun)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   // Raise the strobe and wait (bounded) for the capture; returns at the first
   // negedge with busy high, then scrambles the inputs to prove they were latched.
   task automatic start_sample(input string tag, input logic [15:0] d, input logic [15:0] g);
      int k;
      data_in   = d;
      gain      = g;
      adc_clock = 1'b1;
      k = 0;
      while (!busy && k < 10) begin
         @(negedge clk);
         k++;
      end
      chk({tag, "_capture"}, {31'd0, busy}, 32'd1);
      adc_clock = 1'b0;
      data_in   = ~d;
      gain      = ~g;
   endtask

   // lat0 = negedges already elapsed since the capture negedge.
   task automatic finish_sample(input string tag, input int lat0,
                                input logic [15:0] exp_out, input logic exp_sat);
      int lat;
      int busy_cnt;
      int extra;
      lat      = lat0;
      busy_cnt = lat0 + 1;
      while (!sample_valid && lat < 40) begin
         @(negedge clk);
         lat++;
         if (busy) busy_cnt++;
      end
      chk({tag, "_latency"}, lat, 17);
      chk({tag, "_busy_cycles"}, busy_cnt, 17);
      chk({tag, "_out"}, {16'd0, sample_out}, {16'd0, exp_out});
      chk({tag, "_sat"}, {31'd0, sat}, {31'd0, exp_sat});
      extra = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (sample_valid) extra++;
      end
      chk({tag, "_single_valid"}, extra, 0);
      chk({tag, "_hold"}, {15'd0, sat, sample_out}, {15'd0, exp_sat, exp_out});
   endtask

   initial begin
      int vcount;
      rst_n     = 1'b0;
      adc_clock = 1'b0;
      data_in   = '0;
      gain      = '0;
      repeat (3) @(negedge clk);
      chk("rst_out",     {16'd0, sample_out}, 32'd0);
      chk("rst_valid",   {31'd0, sample_valid}, 32'd0);
      chk("rst_busy",    {31'd0, busy}, 32'd0);
      chk("rst_sat",     {31'd0, sat}, 32'd0);
      chk("rst_overrun", {31'd0, overrun}, 32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // unity gain
      start_sample("unity", 16'h1000, 16'h0100);
      finish_sample("unity", 0, 16'h1000, 1'b0);
      chk("unity_no_overrun", {31'd0, overrun}, 32'd0);

      // 0x4000 * 3.0 = 49152 -> clip high
      start_sample("sat_pos", 16'h4000, 16'h0300);
      finish_sample("sat_pos", 0, 16'h7FFF, 1'b1);

      // -16384 * 3.0 = -49152 -> clip low
      start_sample("sat_neg", 16'hC000, 16'h0300);
      finish_sample("sat_neg", 0, 16'h8000, 1'b1);

      // -32768 * 0.5 = -16384
      start_sample("half_min", 16'h8000, 16'h0080);
      finish_sample("half_min", 0, 16'hC000, 1'b0);

      // -1 * 0.5 = -0.5 -> floor gives -1
      start_sample("trunc", 16'hFFFF, 16'h0080);
      finish_sample("trunc", 0, 16'hFFFF, 1'b0);

      // zero gain still takes the full latency
      start_sample("gain_zero", 16'h7FFF, 16'h0000);
      finish_sample("gain_zero", 0, 16'h0000, 1'b0);
      chk("pre_overrun_clear", {31'd0, overrun}, 32'd0);

      // second strobe while busy: dropped, flagged, first result intact
      start_sample("ovr", 16'h0200, 16'h0180);
      @(negedge clk);
      @(negedge clk);
      adc_clock = 1'b1;
      finish_sample("ovr", 2, 16'h0300, 1'b0);
      chk("ovr_flag", {31'd0, overrun}, 32'd1);
      adc_clock = 1'b0;
      vcount = 0;
      for (int i = 0; i < 25; i++) begin
         @(negedge clk);
         if (sample_valid) vcount++;
      end
      chk("ovr_no_second_valid", vcount, 0);
      chk("ovr_sticky", {31'd0, overrun}, 32'd1);

      // reset part-way through a multiply
      start_sample("abort", 16'h1234, 16'h0100);
      repeat (7) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("abort_out",     {16'd0, sample_out}, 32'd0);
      chk("abort_valid",   {31'd0, sample_valid}, 32'd0);
      chk("abort_busy",    {31'd0, busy}, 32'd0);
      chk("abort_sat",     {31'd0, sat}, 32'd0);
      chk("abort_overrun", {31'd0, overrun}, 32'd0);
      vcount = 0;
      for (int i = 0; i < 25; i++) begin
         @(negedge clk);
         if (sample_valid) vcount++;
      end
      chk("abort_no_valid", vcount, 0);

      // first strobe after reset is captured normally
      start_sample("post_rst", 16'h0100, 16'h0200);
      finish_sample("post_rst", 0, 16'h0200, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule : tb_gain_stage
